// File: rtl/id_exe_reg_if.sv
// ID->EXE pipeline register bus: ID-side fields and controls in, EXE-side registered fields out.
// `ID_FWD_SRC_EN adds the source register numbers used by the EXE forwarding unit.
interface id_exe_reg_if #(
  parameter int BCNT_W = 16
);
  logic              mem_stall;
  logic              flush;
  logic              hazard;
  logic              cond_pass;
  logic [9:0]        ctrl_in;
  logic [31:0]       pc_in;
  logic [31:0]       val_rn_in;
  logic [31:0]       val_rm_in;
  logic              imm_in;
  logic [11:0]       shift_operand_in;
  logic [23:0]       signed_imm24_in;
  logic [3:0]        dest_in;
  logic              sr_c_in;

  logic [3:0]        exe_cmd;
  logic              mem_read;
  logic              mem_write;
  logic              wb_en;
  logic              b;
  logic              s;
  logic              valid;
  logic [31:0]       pc;
  logic [31:0]       val_rn;
  logic [31:0]       val_rm;
  logic              imm;
  logic [11:0]       shift_operand;
  logic [23:0]       signed_imm24;
  logic [3:0]        dest;
  logic              sr_c;
  logic [BCNT_W-1:0] bubble_cnt;

`ifdef ID_FWD_SRC_EN
  logic [3:0]        src1_in;
  logic [3:0]        src2_in;
  logic [3:0]        src1;
  logic [3:0]        src2;
`endif

  modport master (
`ifdef ID_FWD_SRC_EN
    output src1_in, src2_in,
    input  src1, src2,
`endif
    output mem_stall, flush, hazard, cond_pass, ctrl_in, pc_in, val_rn_in, val_rm_in,
           imm_in, shift_operand_in, signed_imm24_in, dest_in, sr_c_in,
    input  exe_cmd, mem_read, mem_write, wb_en, b, s, valid, pc, val_rn, val_rm,
           imm, shift_operand, signed_imm24, dest, sr_c, bubble_cnt
  );

  modport slave (
`ifdef ID_FWD_SRC_EN
    input  src1_in, src2_in,
    output src1, src2,
`endif
    input  mem_stall, flush, hazard, cond_pass, ctrl_in, pc_in, val_rn_in, val_rm_in,
           imm_in, shift_operand_in, signed_imm24_in, dest_in, sr_c_in,
    output exe_cmd, mem_read, mem_write, wb_en, b, s, valid, pc, val_rn, val_rm,
           imm, shift_operand, signed_imm24, dest, sr_c, bubble_cnt
  );
endinterface

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: stall hold, bubble insertion on flush/hazard, saturating bubble counter.
// `ID_FWD_SRC_EN adds registered src1/src2 for the forwarding unit.
module id_exe_reg #(
  parameter int BCNT_W = 16
) (
  input logic         clk,
  input logic         rst,
  id_exe_reg_if.slave bus
);

  // {exe_cmd[3:0], mem_read, mem_write, wb_en, b, s}; two_src stays in ID
  logic [8:0]        ctrl_reg;
  logic              valid_reg;
  logic [31:0]       pc_reg;
  logic [31:0]       val_rn_reg;
  logic [31:0]       val_rm_reg;
  logic              imm_reg;
  logic [11:0]       shift_operand_reg;
  logic [23:0]       signed_imm24_reg;
  logic [3:0]        dest_reg;
  logic              sr_c_reg;
  logic [BCNT_W-1:0] bcnt_reg;
`ifdef ID_FWD_SRC_EN
  logic [3:0]        src1_reg;
  logic [3:0]        src2_reg;
`endif

  logic bubble;
  assign bubble = bus.flush | bus.hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_reg          <= '0;
      valid_reg         <= 1'b0;
      pc_reg            <= '0;
      val_rn_reg        <= '0;
      val_rm_reg        <= '0;
      imm_reg           <= 1'b0;
      shift_operand_reg <= '0;
      signed_imm24_reg  <= '0;
      dest_reg          <= '0;
      sr_c_reg          <= 1'b0;
      bcnt_reg          <= '0;
`ifdef ID_FWD_SRC_EN
      src1_reg          <= '0;
      src2_reg          <= '0;
`endif
    end else if (!bus.mem_stall) begin
      // Datapath fields load even on a bubble; they are ignored while valid is low
      pc_reg            <= bus.pc_in;
      val_rn_reg        <= bus.val_rn_in;
      val_rm_reg        <= bus.val_rm_in;
      imm_reg           <= bus.imm_in;
      shift_operand_reg <= bus.shift_operand_in;
      signed_imm24_reg  <= bus.signed_imm24_in;
      dest_reg          <= bus.dest_in;
      sr_c_reg          <= bus.sr_c_in;
`ifdef ID_FWD_SRC_EN
      src1_reg          <= bus.src1_in;
      src2_reg          <= bus.src2_in;
`endif
      if (bubble) begin
        ctrl_reg  <= '0;
        valid_reg <= 1'b0;
        if (bcnt_reg != {BCNT_W{1'b1}})
          bcnt_reg <= bcnt_reg + 1'b1;
      end else begin
        // A failed condition still retires, as a no-op
        ctrl_reg  <= bus.cond_pass ? bus.ctrl_in[9:1] : 9'd0;
        valid_reg <= 1'b1;
      end
    end
  end

  assign bus.exe_cmd       = ctrl_reg[8:5];
  assign bus.mem_read      = ctrl_reg[4];
  assign bus.mem_write     = ctrl_reg[3];
  assign bus.wb_en         = ctrl_reg[2];
  assign bus.b             = ctrl_reg[1];
  assign bus.s             = ctrl_reg[0];
  assign bus.valid         = valid_reg;
  assign bus.pc            = pc_reg;
  assign bus.val_rn        = val_rn_reg;
  assign bus.val_rm        = val_rm_reg;
  assign bus.imm           = imm_reg;
  assign bus.shift_operand = shift_operand_reg;
  assign bus.signed_imm24  = signed_imm24_reg;
  assign bus.dest          = dest_reg;
  assign bus.sr_c          = sr_c_reg;
  assign bus.bubble_cnt    = bcnt_reg;
`ifdef ID_FWD_SRC_EN
  assign bus.src1          = src1_reg;
  assign bus.src2          = src2_reg;
`endif

endmodule

// File: tb/tb_id_exe_reg.sv
// Scoreboard bench for id_exe_reg (BCNT_W=4): driver queues hand-computed expectations,
// a monitor pops and compares one entry after each clock edge.
module tb_id_exe_reg;
  localparam int BW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  id_exe_reg_if #(.BCNT_W(BW)) bus ();
  id_exe_reg #(.BCNT_W(BW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // ctrl = {valid, exe_cmd, mem_read, mem_write, wb_en, b, s}
  typedef struct packed {
    logic [9:0]    ctrl;
    logic [137:0]  data;
    logic [BW-1:0] bcnt;
  } exp_t;

  exp_t         sb[$];
  logic [137:0] last_data = '0;
  int           n = 0;
  int           checks = 0;
  int           failures = 0;

  function automatic exp_t sample();
    exp_t a;
    a.ctrl = {bus.valid, bus.exe_cmd, bus.mem_read, bus.mem_write, bus.wb_en, bus.b, bus.s};
    a.data = {bus.pc, bus.val_rn, bus.val_rm, bus.imm, bus.shift_operand,
              bus.signed_imm24, bus.dest, bus.sr_c};
    a.bcnt = bus.bubble_cnt;
    return a;
  endfunction

  task automatic cmp(input string name, input logic [137:0] act, input logic [137:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: one queued expectation per clock edge
  always @(posedge clk) begin
    exp_t e;
    exp_t a;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = sample();
      cmp("ctrl", {128'd0, a.ctrl}, {128'd0, e.ctrl});
      cmp("data", a.data, e.data);
      cmp("bcnt", {134'd0, a.bcnt}, {134'd0, e.bcnt});
      cmp("rd_wr_excl", {137'd0, bus.mem_read & bus.mem_write}, 138'd0);
      $display("txn t=%0t ctrl=%b bcnt=%0d dest=%0d val_rn=%h", $time, a.ctrl, a.bcnt,
               bus.dest, bus.val_rn);
    end
  end

  task automatic step(input logic st, input logic fl, input logic hz, input logic cp,
                      input logic [9:0] ctrl, input logic [3:0] d, input logic [31:0] rn,
                      input logic [9:0] ectrl, input logic [BW-1:0] ebc);
    exp_t e;
    @(negedge clk);
    n++;
    bus.mem_stall        = st;
    bus.flush            = fl;
    bus.hazard           = hz;
    bus.cond_pass        = cp;
    bus.ctrl_in          = ctrl;
    bus.pc_in            = 32'h100 + 32'(n * 4);
    bus.val_rn_in        = rn;
    bus.val_rm_in        = ~rn;
    bus.imm_in           = n[0];
    bus.shift_operand_in = 12'h0A0 + n[11:0];
    bus.signed_imm24_in  = {n[11:0], 12'hABC};
    bus.dest_in          = d;
    bus.sr_c_in          = n[1];
`ifdef ID_FWD_SRC_EN
    bus.src1_in          = d;
    bus.src2_in          = ~d;
`endif
    if (!st)
      last_data = {bus.pc_in, bus.val_rn_in, bus.val_rm_in, bus.imm_in, bus.shift_operand_in,
                   bus.signed_imm24_in, bus.dest_in, bus.sr_c_in};
    e.ctrl = ectrl;
    e.data = last_data;
    e.bcnt = ebc;
    sb.push_back(e);
  endtask

  // All inputs high (including stall), then an asynchronous reset pulse between edges
  task automatic do_reset();
    exp_t a;
    @(posedge clk);
    #3;
    bus.mem_stall = 1'b1; bus.flush = 1'b1; bus.hazard = 1'b1; bus.cond_pass = 1'b1;
    bus.ctrl_in = '1; bus.pc_in = '1; bus.val_rn_in = '1; bus.val_rm_in = '1;
    bus.imm_in = 1'b1; bus.shift_operand_in = '1; bus.signed_imm24_in = '1;
    bus.dest_in = '1; bus.sr_c_in = 1'b1;
`ifdef ID_FWD_SRC_EN
    bus.src1_in = '1; bus.src2_in = '1;
`endif
    #3 rst = 1'b1;
    #2;
    a = sample();
    cmp("rst_ctrl", {128'd0, a.ctrl}, 138'd0);
    cmp("rst_data", a.data, 138'd0);
    cmp("rst_bcnt", {134'd0, a.bcnt}, 138'd0);
    $display("txn t=%0t reset ctrl=%b bcnt=%0d", $time, a.ctrl, a.bcnt);
    #1 rst = 1'b0;
    last_data = '0;
  endtask

  localparam logic [9:0] ADD = 10'b0010001001;
  localparam logic [9:0] LDR = 10'b1010101011;
  localparam logic [9:0] STR = 10'b0100010110;

  initial begin
    do_reset();
    // load ADD, then condition fail
    step(0, 0, 0, 1, ADD, 4'h3, 32'h5, {1'b1, 4'b0010, 5'b00100}, 4'd0);
    step(0, 0, 0, 0, ADD, 4'h3, 32'h5, {1'b1, 4'b0000, 5'b00000}, 4'd0);
    // LDR: hazard, then flush+hazard counts once, then real load
    step(0, 0, 1, 1, LDR, 4'h7, 32'h11, 10'd0, 4'd1);
    step(0, 1, 1, 1, LDR, 4'h7, 32'h22, 10'd0, 4'd2);
    step(0, 0, 0, 1, LDR, 4'h7, 32'h33, {1'b1, 4'b1010, 5'b10101}, 4'd2);
    // stall wins over flush for 3 cycles, then the held flush applies
    for (int i = 0; i < 3; i++)
      step(1, 1, 0, 1, ADD, 4'h9, 32'h44 + 32'(i), {1'b1, 4'b1010, 5'b10101}, 4'd2);
    step(0, 1, 0, 1, ADD, 4'h9, 32'h55, 10'd0, 4'd3);
    // STR, then a plain stall holds it
    step(0, 0, 0, 1, STR, 4'hC, 32'hDEAD_BEEF, {1'b1, 4'b0100, 5'b01011}, 4'd3);
    step(1, 0, 0, 1, ADD, 4'h1, 32'h66, {1'b1, 4'b0100, 5'b01011}, 4'd3);
    // 20 flushes: counter saturates at 4'hF
    for (int i = 0; i < 20; i++)
      step(0, 1, 0, 1, ADD, 4'h2, 32'h1000 + 32'(i), 10'd0,
           (3 + i + 1 > 15) ? 4'hF : 4'(3 + i + 1));
    step(0, 0, 1, 1, LDR, 4'h2, 32'h77, 10'd0, 4'hF);
    do_reset();
    // first edge after reset release loads normally
    step(0, 0, 0, 1, ADD, 4'h5, 32'h88, {1'b1, 4'b0010, 5'b00100}, 4'd0);
    step(0, 0, 0, 1, STR, 4'h6, 32'h99, {1'b1, 4'b0100, 5'b01011}, 4'd0);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/id_exe_reg.md
# id_exe_reg

Pipeline register between the decode (ID) and execute (EXE) stages of the ARM pipeline. It captures the decoder's 10-bit control word plus the ID datapath fields on each clock edge. It inserts bubbles on hazards and taken branches, and holds its contents during memory stalls. A saturating counter records the bubbles it inserts, for performance debug.

## Interface
Parameters:
- `BCNT_W`, default 16: width of the bubble counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_stall`  in  1  memory stall; hold every register.
- `flush`  in  1  taken branch in EXE; load a bubble.
- `hazard`  in  1  RAW hazard detected in ID; load a bubble.
- `cond_pass`  in  1  condition check result for the ID instruction.
- `ctrl_in`  in  10  decoder word, with these fields:
  - [9:6] exe_cmd
  - [5] mem_read
  - [4] mem_write
  - [3] wb_en
  - [2] B
  - [1] S
  - [0] two_src
- `pc_in`  in  32  PC+4 of the ID instruction.
- `val_rn_in`, `val_rm_in`  in  32 each  register file read data.
- `imm_in`  in  1  immediate operand flag.
- `shift_operand_in`  in  12  shifter operand field.
- `signed_imm24_in`  in  24  branch offset.
- `dest_in`  in  4  destination register.
- `sr_c_in`  in  1  status register carry flag.
- `src1_in`, `src2_in`  in  4 each  source register numbers. Present only with `ID_FWD_SRC_EN`.
- `exe_cmd`  out  4  registered ctrl_in[9:6].
- `mem_read`, `mem_write`, `wb_en`, `b`, `s`  out  1 each  registered control bits.
- `valid`  out  1  high when the EXE stage holds a real instruction.
- `pc`, `val_rn`, `val_rm`  out  32 each  registered datapath fields.
- `imm`  out  1  registered imm_in.
- `shift_operand`  out  12  registered shift_operand_in.
- `signed_imm24`  out  24  registered signed_imm24_in.
- `dest`  out  4  registered dest_in.
- `sr_c`  out  1  registered sr_c_in.
- `src1`, `src2`  out  4 each  registered source numbers. Present only with `ID_FWD_SRC_EN`.
- `bubble_cnt`  out  BCNT_W  number of inserted bubbles, saturating.

## Operation
Each rising edge performs exactly one action, chosen by this priority: rst > mem_stall > flush > hazard > load.

- **rst** (asynchronous): every output, including `bubble_cnt` and `valid`, goes to 0 immediately, independent of `clk`.
- **mem_stall=1**: every register, including `bubble_cnt`, holds its value. Flush and hazard are ignored that cycle. The branch in EXE is also held, so `flush` stays asserted and is applied once the stall releases.
- **flush=1 or hazard=1** (bubble):
  - All control outputs, `valid`, and `exe_cmd` become 0.
  - Datapath fields (pc, val_rn, val_rm, imm, shift_operand, signed_imm24, dest, sr_c, src1/src2) still load from their inputs. Loading them is harmless because they are don't-care when `valid`=0.
  - `bubble_cnt` increments by 1, saturating at all-ones. flush and hazard together count as one bubble.
- **Load** (none of the above):
  - All fields load from their inputs and `valid` becomes 1.
  - If `cond_pass`=0, then exe_cmd, mem_read, mem_write, wb_en, b and s load 0. `valid` is still 1, because the instruction retires as a no-op. `bubble_cnt` does not change.
  - `ctrl_in[1]` drives `s`.
  - `ctrl_in[0]` (two_src) is consumed only by the ID hazard unit and is not registered.
- Invariant: `mem_read` and `mem_write` are never both 1 at the output. ctrl_in guarantees this, and the bench asserts it.

## Timing
- Latency is one cycle from input to output. Outputs are registered only, with no combinational path from inputs to outputs.
- A bubble is visible on the outputs in the cycle after flush or hazard is sampled high.
- A mem_stall of N cycles holds the outputs for exactly N cycles. The action pending after the stall follows the priority rule on the first edge after mem_stall falls.
- If reset is deasserted mid-pipeline, the first edge after deassertion performs a normal load.
- `bubble_cnt` at all-ones stays at all-ones on further bubbles. Only rst clears it.

## Configuration
- `ID_FWD_SRC_EN` defined:
  - `src1_in`/`src2_in` and `src1`/`src2` exist.
  - They are registered with the same load and hold rules as the other datapath fields.
  - They feed the EXE forwarding unit.
- `ID_FWD_SRC_EN` undefined: those four ports are absent and the block contains no source-number flops.

## Test plan
- Reset: drive all inputs to 1s, then pulse rst mid-cycle -> all outputs are 0 before the next clk edge, and bubble_cnt=0.
- Load ADD: ctrl_in=10'b0010001001, cond_pass=1, dest_in=4'h3, val_rn_in=32'h5 -> next cycle exe_cmd=4'b0010, wb_en=1, s=0, valid=1, dest=3, val_rn=5.
- Condition fail: same ADD with cond_pass=0 -> next cycle exe_cmd=0, wb_en=0, valid=1, bubble_cnt unchanged.
- Hazard then flush, LDR word (ctrl_in=10'b1010101011):
  - hazard=1 for 1 cycle -> mem_read=0, valid=0, bubble_cnt=1.
  - Next cycle, flush=1 and hazard=1 together -> bubble_cnt=2.
- Stall priority: mem_stall=1 and flush=1 for 3 cycles -> outputs are unchanged for 3 cycles and bubble_cnt is unchanged. On release with flush=1, the next edge gives valid=0 and bubble_cnt+1.
- Saturation: run with BCNT_W=4 and apply 20 consecutive flushes -> bubble_cnt=4'hF.
